// File: rtl/led_ctrl_pkg.sv
// Shared encodings and helpers for the LED pattern sequencer.
package led_ctrl_pkg;

    localparam logic [1:0] MODE_RUN   = 2'd0;
    localparam logic [1:0] MODE_PING  = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_BCNT  = 2'd3;

    localparam logic [7:0] LED_ALL_OFF = 8'hFF;
    localparam logic [7:0] LED_ALL_ON  = 8'h00;

    // LAT_NONE lets the first tick after reset always restart a sequence.
    typedef enum logic [2:0] {
        LAT_RUN   = {1'b0, MODE_RUN},
        LAT_PING  = {1'b0, MODE_PING},
        LAT_BLINK = {1'b0, MODE_BLINK},
        LAT_BCNT  = {1'b0, MODE_BCNT},
        LAT_NONE  = 3'd4
    } lat_mode_t;

    function automatic lat_mode_t to_lat(input logic [1:0] m);
        return lat_mode_t'({1'b0, m});
    endfunction

    function automatic logic [7:0] pos_led(input logic [2:0] p);
        return ~(8'h80 >> p);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: divides clk by BASE_DIV >> speed, honours hold and speed changes.
module led_tick_gen #(
    parameter int unsigned BASE_DIV = 12000000,
    parameter int unsigned WIDTH    = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] speed,
    input  logic       hold,
    output logic       tick
);

    localparam logic [WIDTH-1:0] BASE = WIDTH'(BASE_DIV);

    logic [WIDTH-1:0] pcnt;
    logic [WIDTH-1:0] div_m1;
    logic [1:0]       speed_q;
    logic             speed_chg;

    assign div_m1    = (BASE >> speed) - WIDTH'(1);
    assign speed_chg = (speed != speed_q);
    assign tick      = !speed_chg && !hold && (pcnt == div_m1);

    // A speed change clears the count and suppresses any tick that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt    <= '0;
            speed_q <= 2'd0;
        end else begin
            speed_q <= speed;
            if (speed_chg)
                pcnt <= '0;
            else if (hold)
                pcnt <= pcnt;
            else if (tick)
                pcnt <= '0;
            else
                pcnt <= pcnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer: mode latch, pattern FSM and registered active-low outputs.
// Define LED_PATTERN_BINCNT_EN to build mode 3 as binary count; otherwise mode 3 runs like mode 0.
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned BASE_DIV = 12000000,
    parameter int unsigned WIDTH    = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic [1:0] speed,
    input  logic       hold,
    output logic [7:0] led,
    output logic       step
);

    logic      tick;
    lat_mode_t lat_q;
    lat_mode_t lat_new;
    logic      restart;
    logic [2:0] pos;
    logic [2:0] pos_nx;
    logic       dir;
    logic       ph;
`ifdef LED_PATTERN_BINCNT_EN
    logic [7:0] bc;
`endif

    led_tick_gen #(
        .BASE_DIV (BASE_DIV),
        .WIDTH    (WIDTH)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .speed (speed),
        .hold  (hold),
        .tick  (tick)
    );

    assign lat_new = to_lat(mode);
    assign restart = (lat_new != lat_q);
    assign pos_nx  = dir ? (pos - 3'd1) : (pos + 3'd1);

    // dir = 1 means moving down; it flips on arriving at either end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_q <= LAT_NONE;
            pos   <= 3'd0;
            dir   <= 1'b0;
            ph    <= 1'b0;
            led   <= LED_ALL_OFF;
            step  <= 1'b0;
`ifdef LED_PATTERN_BINCNT_EN
            bc    <= 8'd0;
`endif
        end else begin
            step <= tick;
            if (tick) begin
                lat_q <= lat_new;
                case (lat_new)
                    LAT_PING: begin
                        if (restart) begin
                            pos <= 3'd0;
                            dir <= 1'b0;
                            led <= pos_led(3'd0);
                        end else begin
                            pos <= pos_nx;
                            if (pos_nx == 3'd7)
                                dir <= 1'b1;
                            else if (pos_nx == 3'd0)
                                dir <= 1'b0;
                            led <= pos_led(pos_nx);
                        end
                    end
                    LAT_BLINK: begin
                        if (restart) begin
                            ph  <= 1'b0;
                            led <= LED_ALL_ON;
                        end else begin
                            ph  <= ~ph;
                            led <= ph ? LED_ALL_ON : LED_ALL_OFF;
                        end
                    end
`ifdef LED_PATTERN_BINCNT_EN
                    LAT_BCNT: begin
                        if (restart) begin
                            bc  <= 8'd1;
                            led <= ~8'd1;
                        end else begin
                            bc  <= bc + 8'd1;
                            led <= ~(bc + 8'd1);
                        end
                    end
`endif
                    default: begin
                        if (restart) begin
                            pos <= 3'd0;
                            led <= pos_led(3'd0);
                        end else begin
                            pos <= pos + 3'd1;
                            led <= pos_led(pos + 3'd1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl with BASE_DIV=16.
module tb_led_pattern_ctrl;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode  = 2'd0;
    logic [1:0] speed = 2'd0;
    logic       hold  = 1'b0;
    logic [7:0] led;
    logic       step;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state: step index within the latched mode's sequence.
    int         m_cnt;
    int         m_lat;
    int         m_k;
    logic [1:0] m_prev_speed;
    logic [7:0] exp_led;
    logic       exp_step;

    logic [7:0] run_tab  [8]  = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    logic [7:0] ping_tab [15] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE,
                                  8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] blink_tab[3]  = '{8'h00, 8'hFF, 8'h00};

    always #5 clk = ~clk;

    led_pattern_ctrl #(
        .BASE_DIV (16),
        .WIDTH    (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .speed (speed),
        .hold  (hold),
        .led   (led),
        .step  (step)
    );

    // Display value for step k of a mode, straight from the pattern rules.
    function automatic logic [7:0] led_for(input int m, input int k);
        int p;
        case (m)
            1: begin
                p = k % 14;
                if (p >= 8) p = 14 - p;
                return ~(8'h80 >> p);
            end
            2: return ((k % 2) == 1) ? 8'hFF : 8'h00;
`ifdef LED_PATTERN_BINCNT_EN
            3: return ~8'((k + 1) % 256);
`endif
            default: return ~(8'h80 >> (k % 8));
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt        <= 0;
            m_lat        <= -1;
            m_k          <= 0;
            m_prev_speed <= 2'd0;
            exp_led      <= 8'hFF;
            exp_step     <= 1'b0;
        end else begin
            m_prev_speed <= speed;
            exp_step     <= 1'b0;
            if (speed != m_prev_speed) begin
                m_cnt <= 0;
            end else if (hold) begin
                m_cnt <= m_cnt;
            end else if (m_cnt == (16 >> speed) - 1) begin
                m_cnt    <= 0;
                exp_step <= 1'b1;
                if (int'(mode) != m_lat) begin
                    m_lat   <= int'(mode);
                    m_k     <= 0;
                    exp_led <= led_for(int'(mode), 0);
                end else begin
                    m_k     <= m_k + 1;
                    exp_led <= led_for(int'(mode), m_k + 1);
                end
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [1:0] s, input logic h, input int n);
        mode  = m;
        speed = s;
        hold  = h;
        repeat (n) @(negedge clk);
    endtask

    task automatic waitStep(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc = cyc + 1;
        end while (!step && cyc < 300);
        if (!step) checkOutput("step_timeout", {31'd0, step}, 32'd1);
    endtask

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("cycle_led", {24'd0, led}, {24'd0, exp_led});
            checkOutput("cycle_step", {31'd0, step}, {31'd0, exp_step});
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        applyStimulus(2'd0, 2'd0, 1'b0, 3);
        checkOutput("reset_led", {24'd0, led}, 32'hFF);
        checkOutput("reset_step", {31'd0, step}, 32'd0);
        rst_n = 1'b1;

        // Run pattern with wrap.
        waitStep(c);
        checkOutput("first_step_cycle", c, 16);
        checkOutput("run_first", {24'd0, led}, 32'h7F);
        for (int i = 1; i <= 8; i++) begin
            waitStep(c);
            checkOutput("run_period", c, 16);
            checkOutput("run_led", {24'd0, led}, {24'd0, run_tab[i % 8]});
        end

        // Ping-pong, full period plus the return to the start.
        mode = 2'd1;
        for (int i = 0; i < 15; i++) begin
            waitStep(c);
            checkOutput("ping_led", {24'd0, led}, {24'd0, ping_tab[i]});
        end

        // Blink, then switch to run between ticks.
        mode = 2'd2;
        for (int i = 0; i < 3; i++) begin
            waitStep(c);
            checkOutput("blink_led", {24'd0, led}, {24'd0, blink_tab[i]});
        end
        applyStimulus(2'd2, 2'd0, 1'b0, 3);
        applyStimulus(2'd0, 2'd0, 1'b0, 3);
        checkOutput("pre_switch_led", {24'd0, led}, 32'h00);
        waitStep(c);
        checkOutput("switch_run_led", {24'd0, led}, 32'h7F);

        // Hold freezes the prescaler mid-count.
        applyStimulus(2'd0, 2'd0, 1'b0, 5);
        applyStimulus(2'd0, 2'd0, 1'b1, 40);
        checkOutput("hold_led", {24'd0, led}, 32'h7F);
        hold = 1'b0;
        waitStep(c);
        checkOutput("hold_resume_cycles", c, 11);
        checkOutput("hold_resume_led", {24'd0, led}, 32'hBF);

        // Speed 3: one cleared cycle, then a step every 2 cycles.
        speed = 2'd3;
        waitStep(c);
        checkOutput("speed3_first", c, 3);
        checkOutput("speed3_led0", {24'd0, led}, 32'hDF);
        waitStep(c);
        checkOutput("speed3_period", c, 2);
        checkOutput("speed3_led1", {24'd0, led}, 32'hEF);
        waitStep(c);
        checkOutput("speed3_period", c, 2);
        checkOutput("speed3_led2", {24'd0, led}, 32'hF7);

        // Mode 3, back at speed 0 (the speed change costs one cleared cycle).
        speed = 2'd0;
        mode  = 2'd3;
        waitStep(c);
        checkOutput("mode3_first_cycles", c, 17);
`ifdef LED_PATTERN_BINCNT_EN
        checkOutput("bcnt_1", {24'd0, led}, 32'hFE);
        waitStep(c);
        checkOutput("bcnt_2", {24'd0, led}, 32'hFD);
        waitStep(c);
        checkOutput("bcnt_3", {24'd0, led}, 32'hFC);
        for (int i = 4; i <= 255; i++) waitStep(c);
        checkOutput("bcnt_255", {24'd0, led}, 32'h00);
        waitStep(c);
        checkOutput("bcnt_wrap", {24'd0, led}, 32'hFF);
        waitStep(c);
        checkOutput("bcnt_after_wrap", {24'd0, led}, 32'hFE);
`else
        checkOutput("mode3_run_0", {24'd0, led}, 32'h7F);
        waitStep(c);
        checkOutput("mode3_run_1", {24'd0, led}, 32'hBF);
`endif

        // Asynchronous reset between clock edges.
        repeat (7) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_led", {24'd0, led}, 32'hFF);
        checkOutput("async_reset_step", {31'd0, step}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        waitStep(c);
        checkOutput("post_reset_cycles", c, 16);
`ifdef LED_PATTERN_BINCNT_EN
        checkOutput("post_reset_led", {24'd0, led}, 32'hFE);
`else
        checkOutput("post_reset_led", {24'd0, led}, 32'h7F);
`endif

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
